// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, valid/ready in and out.
// Optional SEQ_DIV_ZERO_FAST_EN: a zero divisor finishes after a single CALC cycle.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dq_q, dq_d;     // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   pr_shift, diff;
  logic             zero_fast;

`ifdef SEQ_DIV_ZERO_FAST_EN
  assign zero_fast = dbz_q;
`else
  assign zero_fast = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dq_d        = dq_q;
    div_d       = div_q;
    pr_d        = pr_q;
    cnt_d       = cnt_q;
    dbz_d       = dbz_q;
    pr_shift    = {pr_q, dq_q[WIDTH-1]};
    diff        = pr_shift - {1'b0, div_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dq_d    = a;
          div_d   = b;
          pr_d    = '0;
          cnt_d   = '0;
          dbz_d   = (b == '0);
          state_d = CALC;
        end
      end
      CALC: begin
        if (zero_fast) begin
          // dq_q still holds the untouched dividend on the first CALC cycle
          dq_d    = '1;
          pr_d    = dq_q;
          state_d = DONE;
        end else begin
          if (!diff[WIDTH]) begin
            pr_d = diff[WIDTH-1:0];
            dq_d = {dq_q[WIDTH-2:0], 1'b1};
          end else begin
            pr_d = pr_shift[WIDTH-1:0];
            dq_d = {dq_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dq_q        <= '0;
      div_q       <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dq_q        <= dq_d;
      div_q       <= div_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign q           = dq_q;
  assign r           = pr_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed plus randomized checks of seq_restoring_divider against plain integer division.
module tb_seq_restoring_divider;

  localparam int W = 8;
`ifdef SEQ_DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction; call just after a rising edge with the DUT idle.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input int stall, input bit hold_valid, input bit quiet);
    int lat;
    logic [W-1:0] exp_q, exp_r;
    logic exp_z;
    exp_z = (tb_ == 0);
    exp_q = exp_z ? {W{1'b1}} : W'(int'(ta) / int'(tb_));
    exp_r = exp_z ? ta : W'(int'(ta) % int'(tb_));
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    if (hold_valid) begin a = ~ta; b = tb_ + 8'd1; end
    else in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_z ? ZLAT : W));
    check({tag, ".q"}, 32'(q), 32'(exp_q));
    check({tag, ".r"}, 32'(r), 32'(exp_r));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(exp_z));
    if (!exp_z) begin
      check({tag, ".identity"}, int'(q) * int'(tb_) + int'(r), 32'(ta));
      check({tag, ".r_lt_b"}, 32'(r < tb_), 32'd1);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".stall_q"}, 32'(q), 32'(exp_q));
      check({tag, ".stall_r"}, 32'(r), 32'(exp_r));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    if (!quiet)
      $display("[TB] %s a=%0d b=%0d q=%0d r=%0d dbz=%0b lat=%0d", tag, ta, tb_, q, r, div_by_zero, lat);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #12;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.q", 32'(q), 32'd0);
    check("reset.r", 32'(r), 32'd0);
    check("reset.dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("basic_200_7", 8'd200, 8'd7, 0, 1'b0, 1'b0);
    run_op("b2b_255_1", 8'd255, 8'd1, 0, 1'b1, 1'b0);
    run_op("b2b_5_9", 8'd5, 8'd9, 0, 1'b1, 1'b0);
    run_op("divzero_100", 8'd100, 8'd0, 0, 1'b0, 1'b0);
    run_op("divzero_0", 8'd0, 8'd0, 0, 1'b0, 1'b0);
    run_op("stall_37_6", 8'd37, 8'd6, 5, 1'b0, 1'b0);
    run_op("max_255_255", 8'd255, 8'd255, 0, 1'b0, 1'b0);

    // Asynchronous reset three iterations into CALC
    a = 8'd77; b = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.out_valid", 32'(out_valid), 32'd0);
    check("midreset.in_ready", 32'(in_ready), 32'd1);
    check("midreset.q", 32'(q), 32'd0);
    check("midreset.r", 32'(r), 32'd0);
    check("midreset.dbz", 32'(div_by_zero), 32'd0);
    $display("[TB] midreset in_ready=%0b out_valid=%0b q=%0d r=%0d", in_ready, out_valid, q, r);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_reset_9_3", 8'd9, 8'd3, 0, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(1, 255));
      run_op("rand", ra, rb, 0, 1'b0, (n % 100) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Multi-cycle unsigned restoring divider: the consumer side of the ripple adder/subtractor datapath, turning repeated trial subtraction into quotient and remainder. It accepts one dividend/divisor pair over a valid/ready handshake, iterates one quotient bit per clock, and returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It sits beside the adder/subtractor in the arithmetic unit and serves operations too costly to do combinationally.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept (high only in IDLE)
- a  input  WIDTH  dividend, unsigned
- b  input  WIDTH  divisor, unsigned
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  downstream accepts result
- q  output  WIDTH  quotient
- r  output  WIDTH  remainder
- div_by_zero  output  1  b was 0 for this result

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a into shift register, b into divisor register, clear partial remainder (WIDTH+1 bits), count=0, latch div_by_zero=(b==0); go CALC.
- CALC, one iteration per edge: pr' = {pr[WIDTH-1:0], dividend MSB}; diff = pr' − {1'b0,divisor} in WIDTH+1 bits; if diff sign bit 0, pr=diff and shift quotient bit 1 in, else pr=pr' and shift 0 in; dividend shifts left. count increments; on the iteration where count==WIDTH−1, go DONE.
- DONE: out_valid=1; q, r, div_by_zero held stable until out_valid&&out_ready, then go IDLE. in_valid ignored in DONE/CALC.
- Divide by zero: q = all ones, r = a, div_by_zero=1 (falls out of the algorithm naturally).
- Identity: for b≠0, a == q*b + r and r < b.
- Reset (any state, asynchronous): state=IDLE, q=0, r=0, div_by_zero=0, out_valid=0, in_ready=1 immediately; any in-flight operation is discarded.

## Timing
- Accept on edge T; out_valid rises after edge T+WIDTH (8 cycles for WIDTH=8).
- Output handshake on edge U returns to IDLE; in_ready high in the cycle after U. Minimum issue interval WIDTH+2 cycles.
- in_ready and out_valid are pure decodes of state registers; no combinational path from in_valid/out_ready to any output.
- out_ready held low: DONE persists indefinitely with outputs unchanged.
- q/r are valid only while out_valid=1; values outside DONE are unspecified except after reset (0).

## Configuration
- SEQ_DIV_ZERO_FAST_EN defined: when b==0 at acceptance, skip CALC; go straight to DONE with q=all ones, r=a, div_by_zero=1; out_valid rises after edge T+1.
- Undefined: divide by zero runs the full WIDTH iterations (same results, latency WIDTH). Non-zero divisors identical in both builds.

## Test plan
- a=200, b=7, out_ready=1 -> out_valid after 8 edges, q=28, r=4, div_by_zero=0, then in_ready=1 next cycle.
- a=255, b=1 and a=5, b=9 back-to-back -> q=255,r=0 then q=0,r=5; in_valid held high during CALC/DONE does not load new operands.
- a=100, b=0 -> q=255, r=100, div_by_zero=1; latency 1 edge with SEQ_DIV_ZERO_FAST_EN, 8 without.
- a=37, b=6, out_ready low for 5 cycles after out_valid -> q=6, r=1 held stable throughout; completes on first out_ready high.
- rst_n pulsed low mid-CALC (after 3 iterations) -> out_valid=0, q=r=0, in_ready=1 asynchronously; next operation a=9, b=3 yields q=3, r=0.
- Randomized sweep of 1000 non-zero pairs -> a==q*b+r, r<b, latency exactly 8.
